play_core: RTL and testbench
============================

// Module: play_core
// PURPOSE
//  Playback engine: downstream consumer of the recorder's SDRAM image. On start, reads the
//  length word at base, then fetches samples base+1..base+len into a prefetch FIFO and streams
//  them to the audio DAC interface over valid/ready. Sits between the top controller, the
//  SDRAM arbiter port and the audio output path.
// PARAMETERS
//  FIFO_DEPTH  4   prefetch entries (power of 2, >=2)
//  ADDR_W      23  SDRAM word address width
// PORTS
//  i_clk                 in   1       system clock
//  i_rst_n               in   1       async active-low reset
//  play_start            in   1       1-cycle pulse; accepted only in IDLE
//  play_select           in   ADDR_W  base address (length word); sampled at start
//  play_pause            in   1       level; freezes fetch and output while high
//  play_stop             in   1       pulse; aborts playback
//  play_done             out  1       1-cycle pulse on completion or abort
//  play_read             out  1       SDRAM read request, held until finished
//  play_addr             out  ADDR_W  SDRAM address
//  play_readdata         in   32      SDRAM read data, valid when finished=1
//  play_sdram_finished   in   1       SDRAM access complete (1 cycle)
//  play_audio_data       out  32      sample to DAC path
//  play_audio_valid      out  1       sample valid
//  play_audio_ready      in   1       DAC path accepts sample this cycle
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; FIFO empty; len/ptr/count registers 0.
//  States: IDLE -> READ_LEN -> STREAM -> DRAIN -> IDLE.
//  IDLE: on play_start latch base; next cycle READ_LEN.
//  READ_LEN: play_read=1, play_addr=base; on finished len=readdata[ADDR_W-1:0], ptr=base+1,
//   remaining=len. len==0 -> pulse play_done, IDLE.
//  STREAM: issue read at ptr when FIFO has a free slot (counting the outstanding read),
//   remaining!=0 and !play_pause. play_read/play_addr stable until finished; on finished push
//   readdata, ptr+=1, remaining-=1. remaining==0 after push -> DRAIN.
//  Only one SDRAM read outstanding; play_read deasserts the cycle after finished.
//  Output: play_audio_valid = FIFO non-empty && !play_pause; data = FIFO head; pop on
//   valid&&ready. Data held stable while valid&&!ready. Push and pop in the same cycle legal
//   (full FIFO: pop frees the slot for the next request, no overflow).
//  DRAIN: no reads; on FIFO empty pulse play_done, IDLE.
//  Pause asserted mid-read: the outstanding read completes and is pushed; no new request.
//  Stop: flush FIFO, valid=0 next cycle. If a read is outstanding, hold play_read until
//   finished, discard data, then play_done + IDLE; otherwise play_done next cycle. Stop in IDLE
//   ignored. Stop has priority over pause and over natural completion in the same cycle.
//  play_start outside IDLE ignored. Address arithmetic is mod 2^ADDR_W (wraps to 0).
//  Total samples delivered == len exactly (absent stop).
// CONFIGURATION
//  PLAY_LOOP_EN defined: in STREAM, when remaining reaches 0 reload ptr=base+1,
//   remaining=len and continue; DRAIN and natural play_done never occur; only play_stop ends
//   playback (len==0 still ends at READ_LEN).
//  Undefined: single pass as above.
// TESTING
//  1. mem[100]=3, mem[101..103]=A,B,C; start base=100, ready=1 -> reads 100,101,102,103;
//     outputs A,B,C; play_done once; no read of 104.
//  2. mem[200]=0; start -> single read of 200, play_done, valid never asserted.
//  3. len=8, ready=0 -> exactly FIFO_DEPTH reads issued then stall; ready=1 -> all 8 samples
//     in order, no loss or duplication.
//  4. len=6, pause for 20 cycles after 2nd sample -> valid=0 and no new read while paused;
//     resume delivers remaining 4 in order.
//  5. stop while play_read=1 waiting on finished -> read held to finished, FIFO flushed,
//     play_done 1 cycle later, IDLE; a start afterwards replays from sample 1.
//  6. PLAY_LOOP_EN, len=2 (X,Y) -> X,Y,X,Y,... until stop; async i_rst_n low mid-stream ->
//     all outputs 0 immediately.

Source files
------------

// File: rtl/play_core.sv
// play_core: playback engine that reads a length-prefixed sample image from SDRAM
// (length word at base, samples at base+1..base+len) through a small prefetch FIFO
// and streams the samples to the audio DAC path over a valid/ready handshake.
// Optional build macro PLAY_LOOP_EN: replay the image endlessly until play_stop.
module play_core #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 23
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              play_start,
  input  logic [ADDR_W-1:0] play_select,
  input  logic              play_pause,
  input  logic              play_stop,
  output logic              play_done,
  output logic              play_read,
  output logic [ADDR_W-1:0] play_addr,
  input  logic [31:0]       play_readdata,
  input  logic              play_sdram_finished,
  output logic [31:0]       play_audio_data,
  output logic              play_audio_valid,
  input  logic              play_audio_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

  // ABORT parks the engine after a stop until the read already in flight
  // has been acknowledged, so the SDRAM port never sees a dropped request.
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_LEN,
    S_STREAM,
    S_DRAIN,
    S_ABORT
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] remaining_q;
  logic [ADDR_W-1:0] addr_q;
  logic              read_q;
  logic              done_q;

  logic [31:0]       fifoMem [FIFO_DEPTH];
  logic [PW-1:0]     wr_q;
  logic [PW-1:0]     rd_q;
  logic [PW:0]       count_q;
  logic [PW:0]       count_d;

  logic              push;
  logic              pop;
  logic              canIssue;
  logic              unusedBits;

  assign play_read  = read_q;
  assign play_addr  = addr_q;
  assign play_done  = done_q;

  // Output is gated by pause; data is forced to zero whenever nothing is offered.
  assign play_audio_valid = (count_q != '0) && !play_pause;
  assign play_audio_data  = play_audio_valid ? fifoMem[rd_q] : '0;
  assign pop              = play_audio_valid && play_audio_ready;

  // A returning sample read is kept unless a stop arrives in the same cycle.
  assign push    = (state_q == S_STREAM) && read_q && play_sdram_finished && !play_stop;
  assign count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

  // A new request is only made with no read in flight, so count_d already
  // accounts for this cycle's pop and a full FIFO being drained can refill.
  assign canIssue = (state_q == S_STREAM) && !read_q && (remaining_q != '0) &&
                    !play_pause && (count_d < FULL_COUNT);

  // The upper data bits beyond the address width are never part of the length.
  assign unusedBits = ^{play_readdata[31:ADDR_W], len_q};

  // FIFO storage; contents need no reset because data is gated by valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifoMem[wr_q] <= play_readdata;
    end
  end

  // Control FSM, FIFO pointers and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      ptr_q       <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      read_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
    end else begin
      done_q  <= 1'b0;
      count_q <= count_d;
      if (push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (play_start) begin
            base_q  <= play_select;
            addr_q  <= play_select;
            read_q  <= 1'b1;
            state_q <= S_READ_LEN;
          end
        end

        S_READ_LEN: begin
          if (play_stop) begin
            if (play_sdram_finished) begin
              read_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_ABORT;
            end
          end else if (play_sdram_finished) begin
            read_q      <= 1'b0;
            len_q       <= play_readdata[ADDR_W-1:0];
            remaining_q <= play_readdata[ADDR_W-1:0];
            ptr_q       <= base_q + ADDR_W'(1);
            if (play_readdata[ADDR_W-1:0] == '0) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_STREAM;
            end
          end
        end

        S_STREAM: begin
          if (play_stop) begin
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            if (read_q && !play_sdram_finished) begin
              state_q <= S_ABORT;
            end else begin
              read_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            if (canIssue) begin
              read_q <= 1'b1;
              addr_q <= ptr_q;
            end
            if (push) begin
              read_q      <= 1'b0;
              ptr_q       <= ptr_q + ADDR_W'(1);
              remaining_q <= remaining_q - ADDR_W'(1);
              if (remaining_q == ADDR_W'(1)) begin
`ifdef PLAY_LOOP_EN
                ptr_q       <= base_q + ADDR_W'(1);
                remaining_q <= len_q;
`else
                state_q     <= S_DRAIN;
`endif
              end
            end
          end
        end

        S_DRAIN: begin
          if (play_stop) begin
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else if (count_q == '0) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end

        S_ABORT: begin
          if (play_sdram_finished) begin
            read_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          read_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_play_core.sv
// tb_play_core: directed bench for play_core with a latency-configurable SDRAM
// model, a DAC-side ready generator and a monitor collecting delivered samples.
module tb_play_core;

  localparam int ADDR_W     = 23;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              i_rst_n;
  logic              play_start;
  logic [ADDR_W-1:0] play_select;
  logic              play_pause;
  logic              play_stop;
  logic              play_done;
  logic              play_read;
  logic [ADDR_W-1:0] play_addr;
  logic [31:0]       play_readdata;
  logic              play_sdram_finished;
  logic [31:0]       play_audio_data;
  logic              play_audio_valid;
  logic              play_audio_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0]       mem [1024];
  logic [ADDR_W-1:0] readAddrs[$];
  logic [31:0]       gotQ[$];
  int                doneCount = 0;
  int                doneCyc   = 0;
  int                finishCyc = 0;
  int                sdLat     = 2;
  int                sdWait    = 0;
  bit                sdBusy    = 1'b0;
  logic [ADDR_W-1:0] sdAddr;
  int                readyMode = 0;
  bit                holdPending = 1'b0;
  logic [31:0]       holdData;

  typedef struct {
    logic [ADDR_W-1:0] base;
    int                len;
    logic [31:0]       seed;
    int                readyMode;
    int                expReads;
    int                expSamples;
  } vec_t;

  vec_t vecs[5];

  play_core #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk               (clk),
    .i_rst_n             (i_rst_n),
    .play_start          (play_start),
    .play_select         (play_select),
    .play_pause          (play_pause),
    .play_stop           (play_stop),
    .play_done           (play_done),
    .play_read           (play_read),
    .play_addr           (play_addr),
    .play_readdata       (play_readdata),
    .play_sdram_finished (play_sdram_finished),
    .play_audio_data     (play_audio_data),
    .play_audio_valid    (play_audio_valid),
    .play_audio_ready    (play_audio_ready)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Cycle counter used to time done against the last SDRAM acknowledge.
  always @(posedge clk) cyc++;

  // SDRAM model: one request at a time, acknowledged sdLat+1 cycles later;
  // also checks that address and request stay put until acknowledged.
  always @(posedge clk) begin
    #1;
    play_sdram_finished = 1'b0;
    if (sdBusy) begin
      total++;
      if (!play_read || play_addr !== sdAddr) begin
        bad++;
        $display("[TB] FAIL read held: read=%0b addr=%0h want read=1 addr=%0h", play_read, play_addr, sdAddr);
      end
      if (sdWait == 0) begin
        play_sdram_finished = 1'b1;
        play_readdata       = mem[sdAddr[9:0]];
        sdBusy              = 1'b0;
        finishCyc           = cyc;
      end else begin
        sdWait--;
      end
    end else if (play_read) begin
      sdBusy = 1'b1;
      sdAddr = play_addr;
      sdWait = sdLat;
      readAddrs.push_back(play_addr);
    end
  end

  // DAC-side ready: 0 = always ready, 1 = every other cycle, 2 = never.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       play_audio_ready = 1'b1;
      1:       play_audio_ready = ~play_audio_ready;
      default: play_audio_ready = 1'b0;
    endcase
  end

  // Monitor: collects handshakes and done pulses, checks pause gating and hold stability.
  always @(negedge clk) begin
    if (play_done) begin
      doneCount++;
      doneCyc = cyc;
    end
    if (play_audio_valid && play_audio_ready) gotQ.push_back(play_audio_data);
    if (play_pause) begin
      total++;
      if (play_audio_valid) begin
        bad++;
        $display("[TB] FAIL pause gating: valid=%0b want 0", play_audio_valid);
      end
    end
    if (holdPending && play_audio_valid) begin
      total++;
      if (play_audio_data !== holdData) begin
        bad++;
        $display("[TB] FAIL data hold: got=%0h want=%0h", play_audio_data, holdData);
      end
    end
    holdPending = play_audio_valid && !play_audio_ready;
    holdData    = play_audio_data;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic loadImage(input logic [ADDR_W-1:0] base, input int len, input logic [31:0] seed);
    logic [ADDR_W-1:0] a;
    mem[base[9:0]] = 32'(len);
    for (int k = 0; k < len; k++) begin
      a = base + ADDR_W'(k + 1);
      mem[a[9:0]] = seed + 32'(k);
    end
  endtask

  task automatic beginPlay(input logic [ADDR_W-1:0] base);
    gotQ.delete();
    readAddrs.delete();
    doneCount = 0;
    play_select = base;
    play_start  = 1'b1;
    tick();
    play_start  = 1'b0;
  endtask

  task automatic pulseStop();
    play_stop = 1'b1;
    tick();
    play_stop = 1'b0;
  endtask

  task automatic waitDone(input string name, input int maxCyc);
    for (int i = 0; i < maxCyc && doneCount == 0; i++) tick();
    checkOutput({name, " done seen"}, 32'(doneCount != 0), 32'd1);
  endtask

  task automatic finishCheck(input string name, input logic [ADDR_W-1:0] base, input logic [31:0] seed,
                             input int expReads, input int expSamples);
    logic [ADDR_W-1:0] a;
    waitDone(name, 600);
    repeat (8) tick();
    checkOutput({name, " read count"}, 32'(readAddrs.size()), 32'(expReads));
    for (int i = 0; i < readAddrs.size() && i < expReads; i++) begin
      a = base + ADDR_W'(i);
      checkOutput($sformatf("%s read addr %0d", name, i), 32'(readAddrs[i]), 32'(a));
    end
    checkOutput({name, " sample count"}, 32'(gotQ.size()), 32'(expSamples));
    for (int k = 0; k < gotQ.size() && k < expSamples; k++)
      checkOutput($sformatf("%s sample %0d", name, k), gotQ[k], seed + 32'(k));
    checkOutput({name, " done pulses"}, 32'(doneCount), 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    readyMode = v.readyMode;
    sdLat     = 2;
    loadImage(v.base, v.len, v.seed);
    beginPlay(v.base);
    finishCheck($sformatf("vec%0d", idx), v.base, v.seed, v.expReads, v.expSamples);
    readyMode = 0;
  endtask

  initial begin
    int snap;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    i_rst_n             = 1'b0;
    play_start          = 1'b0;
    play_select         = '0;
    play_pause          = 1'b0;
    play_stop           = 1'b0;
    play_readdata       = '0;
    play_sdram_finished = 1'b0;
    play_audio_ready    = 1'b1;

    vecs[0] = '{23'd100,      3, 32'h0000_A000, 0, 4, 3};
    vecs[1] = '{23'd200,      0, 32'h0000_B000, 0, 1, 0};
    vecs[2] = '{23'd300,      5, 32'h0000_C000, 1, 6, 5};
    vecs[3] = '{23'h7F_FFFE,  3, 32'h0000_D000, 0, 4, 3};
    vecs[4] = '{23'd400,      1, 32'h0000_E000, 1, 2, 1};

    // Reset state
    #12;
    checkOutput("reset read",  32'(play_read), 32'd0);
    checkOutput("reset addr",  32'(play_addr), 32'd0);
    checkOutput("reset done",  32'(play_done), 32'd0);
    checkOutput("reset valid", 32'(play_audio_valid), 32'd0);
    checkOutput("reset data",  play_audio_data, 32'd0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // Stop while idle is ignored
    doneCount = 0;
    pulseStop();
    repeat (5) tick();
    checkOutput("idle stop no done", 32'(doneCount), 32'd0);
    checkOutput("idle stop no read", 32'(play_read), 32'd0);

    // Asynchronous reset mid-stream clears outputs without a clock edge
    readyMode = 2;
    loadImage(23'd800, 8, 32'h0000_8000);
    beginPlay(23'd800);
    repeat (60) tick();
    checkOutput("prereset valid", 32'(play_audio_valid), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("async rst valid", 32'(play_audio_valid), 32'd0);
    checkOutput("async rst data",  play_audio_data, 32'd0);
    checkOutput("async rst addr",  32'(play_addr), 32'd0);
    checkOutput("async rst read",  32'(play_read), 32'd0);
    checkOutput("async rst done",  32'(play_done), 32'd0);
    tick();
    sdBusy    = 1'b0;
    readyMode = 0;
    i_rst_n   = 1'b1;
    tick();

`ifdef PLAY_LOOP_EN
    // Loop mode: X,Y repeat until stop
    loadImage(23'd900, 2, 32'h0000_5A00);
    beginPlay(23'd900);
    for (int i = 0; i < 400 && gotQ.size() < 7; i++) tick();
    checkOutput("loop no natural done", 32'(doneCount), 32'd0);
    pulseStop();
    waitDone("loop", 100);
    for (int k = 0; k < 6; k++)
      checkOutput($sformatf("loop sample %0d", k), gotQ[k], 32'h0000_5A00 + 32'(k % 2));
`else
    // Table-driven single-pass playbacks
    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Backpressure: exactly FIFO_DEPTH sample reads, then stall; late start ignored
    readyMode = 2;
    loadImage(23'd500, 8, 32'h0000_5000);
    beginPlay(23'd500);
    repeat (50) tick();
    checkOutput("stall reads", 32'(readAddrs.size()), 32'(1 + FIFO_DEPTH));
    checkOutput("stall no output", 32'(gotQ.size()), 32'd0);
    checkOutput("stall valid", 32'(play_audio_valid), 32'd1);
    play_select = 23'd999;
    play_start  = 1'b1;
    tick();
    play_start  = 1'b0;
    repeat (10) tick();
    checkOutput("busy start ignored", 32'(readAddrs.size()), 32'(1 + FIFO_DEPTH));
    readyMode = 0;
    finishCheck("stall", 23'd500, 32'h0000_5000, 9, 8);

    // Pause after the second sample
    loadImage(23'd600, 6, 32'h0000_6000);
    beginPlay(23'd600);
    for (int i = 0; i < 300 && gotQ.size() < 2; i++) tick();
    play_pause = 1'b1;
    tick();
    tick();
    snap = readAddrs.size();
    repeat (18) tick();
    checkOutput("pause no new read", 32'(readAddrs.size()), 32'(snap));
    checkOutput("pause no output", 32'(gotQ.size()), 32'd2);
    checkOutput("pause valid", 32'(play_audio_valid), 32'd0);
    play_pause = 1'b0;
    finishCheck("pause", 23'd600, 32'h0000_6000, 7, 6);

    // Stop with a sample read in flight and samples queued
    readyMode = 2;
    sdLat     = 2;
    loadImage(23'd700, 6, 32'h0000_7000);
    beginPlay(23'd700);
    for (int i = 0; i < 200 && readAddrs.size() < 3; i++) tick();
    sdLat = 20;
    for (int i = 0; i < 200 && readAddrs.size() < 4; i++) tick();
    repeat (3) tick();
    checkOutput("prestop read", 32'(play_read), 32'd1);
    checkOutput("prestop valid", 32'(play_audio_valid), 32'd1);
    pulseStop();
    @(negedge clk);
    checkOutput("stop flush valid", 32'(play_audio_valid), 32'd0);
    checkOutput("stop read held", 32'(play_read), 32'd1);
    tick();
    waitDone("stop", 100);
    checkOutput("stop done timing", 32'(doneCyc), 32'(finishCyc + 1));
    repeat (10) tick();
    checkOutput("stop read count", 32'(readAddrs.size()), 32'd4);
    checkOutput("stop no output", 32'(gotQ.size()), 32'd0);
    checkOutput("stop done pulses", 32'(doneCount), 32'd1);
    sdLat     = 2;
    readyMode = 0;
    tick();
    beginPlay(23'd700);
    finishCheck("replay", 23'd700, 32'h0000_7000, 7, 6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
